core_mem_arbiter: RTL and testbench

- Shares one memory port between two requesters: instruction fetch (imem, read-only) and execute-stage load/store (dmem).
- Sits between the fetch/execute pipeline stages and the single core memory bus.
- Locks ownership for the whole life of a transaction and prevents fetch starvation.
- The request/grant protocol is identical on the requester and memory sides, so the block drops in transparently.

---
 rtl/core_mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_core_mem_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/core_mem_arbiter.sv
// Two-requester arbiter (fetch / load-store) onto one core memory bus with ownership lock.
// Build option: define CORE_MEM_ARB_RR_EN for round-robin arbitration instead of dmem priority with starvation guard.
module core_mem_arbiter #(
    parameter int MEM_ADDR_W = 64,
    parameter int MEM_DATA_W = 64,
    parameter int MEM_STRB_W = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic                  g_clk,
    input  logic                  g_resetn,
    input  logic                  imem_req,
    input  logic [MEM_ADDR_W-1:0] imem_addr,
    output logic                  imem_gnt,
    output logic                  imem_err,
    output logic [MEM_DATA_W-1:0] imem_rdata,
    input  logic                  dmem_req,
    input  logic [MEM_ADDR_W-1:0] dmem_addr,
    input  logic                  dmem_wen,
    input  logic [MEM_STRB_W-1:0] dmem_strb,
    input  logic [MEM_DATA_W-1:0] dmem_wdata,
    output logic                  dmem_gnt,
    output logic                  dmem_err,
    output logic [MEM_DATA_W-1:0] dmem_rdata,
    output logic                  mem_req,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic                  mem_wen,
    output logic [MEM_STRB_W-1:0] mem_strb,
    output logic [MEM_DATA_W-1:0] mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_err,
    input  logic [MEM_DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   pick_i;
    logic   sel_i, sel_d;
    logic   route_i, route_d;
    logic   done_i, done_d;

`ifdef CORE_MEM_ARB_RR_EN
    logic last_i_q, last_i_d;

    // On conflict the requester that did not complete last goes first.
    assign pick_i = imem_req & (~dmem_req | ~last_i_q);
`else
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    logic [3:0] starve_q, starve_d;

    assign pick_i = imem_req & (~dmem_req | (starve_q == STARVE_LIM));
`endif

    // Owner is the registered lock, or the combinational winner while idle.
    assign sel_i   = (state_q == OWN_I) | ((state_q == IDLE) & pick_i);
    assign sel_d   = (state_q == OWN_D) | ((state_q == IDLE) & ~pick_i & dmem_req);
    assign route_i = sel_i & imem_req;
    assign route_d = sel_d & dmem_req;
    assign done_i  = sel_i & mem_gnt;
    assign done_d  = sel_d & mem_gnt;

    assign mem_req   = route_i | route_d;
    assign mem_addr  = route_i ? imem_addr : (route_d ? dmem_addr : '0);
    assign mem_wen   = route_d & dmem_wen;
    assign mem_strb  = route_d ? dmem_strb : '0;
    assign mem_wdata = route_d ? dmem_wdata : '0;

    assign imem_gnt   = done_i;
    assign dmem_gnt   = done_d;
    assign imem_err   = done_i & mem_err;
    assign dmem_err   = done_d & mem_err;
    assign imem_rdata = mem_rdata;
    assign dmem_rdata = mem_rdata;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!mem_gnt) begin
                    if (route_i) begin
                        state_d = OWN_I;
                    end else if (route_d) begin
                        state_d = OWN_D;
                    end
                end
            end
            // A dropped request abandons the lock as well as a completion does.
            OWN_I: if (mem_gnt || !imem_req) state_d = IDLE;
            OWN_D: if (mem_gnt || !dmem_req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef CORE_MEM_ARB_RR_EN
    always_comb begin
        last_i_d = last_i_q;
        if (done_i) begin
            last_i_d = 1'b1;
        end else if (done_d) begin
            last_i_d = 1'b0;
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q  <= IDLE;
            last_i_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_i_q <= last_i_d;
        end
    end
`else
    always_comb begin
        starve_d = starve_q;
        if (done_i) begin
            starve_d = '0;
        end else if (done_d) begin
            if (!imem_req) begin
                starve_d = '0;
            end else if (starve_q != STARVE_LIM) begin
                starve_d = starve_q + 4'd1;
            end
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end
`endif

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Randomized self-checking bench for core_mem_arbiter against a transaction-level reference model.
module tb_core_mem_arbiter;

    localparam int AW   = 64;
    localparam int DW   = 64;
    localparam int SW   = 8;
    localparam int SMAX = 4;

    logic          g_clk = 1'b0;
    logic          g_resetn = 1'b0;
    logic          imem_req = 1'b0;
    logic [AW-1:0] imem_addr = '0;
    logic          imem_gnt, imem_err;
    logic [DW-1:0] imem_rdata;
    logic          dmem_req = 1'b0;
    logic [AW-1:0] dmem_addr = '0;
    logic          dmem_wen = 1'b0;
    logic [SW-1:0] dmem_strb = '0;
    logic [DW-1:0] dmem_wdata = '0;
    logic          dmem_gnt, dmem_err;
    logic [DW-1:0] dmem_rdata;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_wen;
    logic [SW-1:0] mem_strb;
    logic [DW-1:0] mem_wdata;
    logic          mem_gnt = 1'b0;
    logic          mem_err = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    always #5 g_clk = ~g_clk;

    core_mem_arbiter #(
        .MEM_ADDR_W(AW), .MEM_DATA_W(DW), .MEM_STRB_W(SW), .STARVE_MAX(SMAX)
    ) dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_err(imem_err), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_wen(dmem_wen),
        .dmem_strb(dmem_strb), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
        .dmem_err(dmem_err), .dmem_rdata(dmem_rdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wen(mem_wen),
        .mem_strb(mem_strb), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_err(mem_err), .mem_rdata(mem_rdata)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: who holds the bus, pending requests, and the fairness bookkeeping.
    int            owner;
    int            starve;
    bit            lastI;
    int            lat;
    bit            latSet;
    bit            iPend, dPend;
    logic [AW-1:0] iAddr, dAddr;
    bit            dWen;
    logic [SW-1:0] dStrb;
    logic [DW-1:0] dWdata;
    logic [5:0]    hPat;
    int            hCnt;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        owner  = 0;
        starve = 0;
        lastI  = 1'b0;
        latSet = 1'b0;
        lat    = 0;
        iPend  = 1'b0;
        dPend  = 1'b0;
    endtask

    task automatic doReset();
        @(negedge g_clk);
        g_resetn  = 1'b0;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        mem_gnt   = 1'b0;
        mem_err   = 1'b0;
        mem_rdata = '0;
        @(negedge g_clk);
        #1;
        checkOutput("rst_mem_req", {63'd0, mem_req}, 64'd0);
        g_resetn = 1'b1;
        modelReset();
    endtask

    task automatic applyStimulus(input int nCycles, input int latMax, input int reqPct);
        for (int c = 0; c < nCycles; c++) begin
            int            win;
            bit            gnt;
            bit            err;
            logic [DW-1:0] rd;
            logic [AW-1:0] eAddr;
            @(negedge g_clk);
            if (!iPend && $urandom_range(99) < reqPct) begin
                iPend = 1'b1;
                iAddr = {$urandom, $urandom};
            end
            if (!dPend && $urandom_range(99) < reqPct) begin
                dPend  = 1'b1;
                dAddr  = {$urandom, $urandom};
                dWen   = 1'($urandom_range(1));
                dStrb  = 8'($urandom);
                dWdata = {$urandom, $urandom};
            end
            imem_req   = iPend;
            imem_addr  = iPend ? iAddr : {$urandom, $urandom};
            dmem_req   = dPend;
            dmem_addr  = dPend ? dAddr : {$urandom, $urandom};
            dmem_wen   = dPend ? dWen : 1'($urandom_range(1));
            dmem_strb  = dPend ? dStrb : 8'($urandom);
            dmem_wdata = dPend ? dWdata : {$urandom, $urandom};

            if (owner != 0)           win = owner;
`ifdef CORE_MEM_ARB_RR_EN
            else if (iPend && dPend)  win = lastI ? 2 : 1;
`else
            else if (iPend && dPend)  win = (starve == SMAX) ? 1 : 2;
`endif
            else if (dPend)           win = 2;
            else if (iPend)           win = 1;
            else                      win = 0;

            if (win != 0 && !latSet) begin
                lat    = $urandom_range(latMax);
                latSet = 1'b1;
            end
            gnt = (win != 0) && (lat == 0);
            err = 1'($urandom_range(1));
            rd  = {$urandom, $urandom};
            mem_gnt   = gnt;
            mem_err   = err;
            mem_rdata = rd;
            #1;

            eAddr = (win == 1) ? iAddr : ((win == 2) ? dAddr : '0);
            checkOutput("mem_req", {63'd0, mem_req}, {63'd0, win != 0});
            checkOutput("mem_addr", mem_addr, eAddr);
            checkOutput("mem_wen", {63'd0, mem_wen}, {63'd0, (win == 2) && dWen});
            checkOutput("mem_strb", {56'd0, mem_strb}, (win == 2) ? {56'd0, dStrb} : 64'd0);
            checkOutput("mem_wdata", mem_wdata, (win == 2) ? dWdata : 64'd0);
            checkOutput("imem_gnt", {63'd0, imem_gnt}, {63'd0, gnt && win == 1});
            checkOutput("dmem_gnt", {63'd0, dmem_gnt}, {63'd0, gnt && win == 2});
            checkOutput("imem_err", {63'd0, imem_err}, {63'd0, gnt && err && win == 1});
            checkOutput("dmem_err", {63'd0, dmem_err}, {63'd0, gnt && err && win == 2});
            checkOutput("imem_rdata", imem_rdata, rd);
            checkOutput("dmem_rdata", dmem_rdata, rd);

            if (imem_gnt || dmem_gnt) begin
                hPat = {hPat[4:0], imem_gnt};
                hCnt++;
            end

            if (gnt) begin
                if (win == 1) begin
                    iPend  = 1'b0;
                    starve = 0;
                    lastI  = 1'b1;
                end else begin
                    starve = iPend ? ((starve < SMAX) ? starve + 1 : starve) : 0;
                    dPend  = 1'b0;
                    lastI  = 1'b0;
                end
                owner  = 0;
                latSet = 1'b0;
            end else if (win != 0) begin
                owner = win;
                lat--;
            end
        end
    endtask

    initial begin
        modelReset();
        hPat = '0;
        hCnt = 0;
        @(negedge g_clk);
        @(negedge g_clk);
        #1;
        checkOutput("rst_idle_outputs",
                    {59'd0, mem_req, mem_wen, imem_gnt, dmem_gnt, imem_err | dmem_err}, 64'd0);
        checkOutput("rst_idle_addr", mem_addr | mem_wdata | {56'd0, mem_strb}, 64'd0);
        g_resetn = 1'b1;

        applyStimulus(1500, 3, 40);
        applyStimulus(400, 0, 90);

        // Reset while dmem holds the bus, then fetch / lock / error sequence.
        doReset();
        @(negedge g_clk);
        dmem_req = 1'b1; dmem_addr = 64'h2000; dmem_wen = 1'b0; mem_gnt = 1'b0;
        #1;
        checkOutput("d_own_addr", mem_addr, 64'h2000);
        doReset();
        dmem_req = 1'b0;
        imem_req = 1'b1; imem_addr = 64'h1000;
        #1;
        checkOutput("post_rst_fetch_req", {63'd0, mem_req}, 64'd1);
        checkOutput("post_rst_fetch_addr", mem_addr, 64'h1000);
        @(negedge g_clk);
        dmem_req = 1'b1; dmem_addr = 64'h2000; dmem_wen = 1'b1;
        dmem_strb = 8'h0F; dmem_wdata = 64'h55AA;
        #1;
        checkOutput("lock_addr", mem_addr, 64'h1000);
        checkOutput("lock_wen", {63'd0, mem_wen}, 64'd0);
        @(negedge g_clk);
        mem_gnt = 1'b1; mem_rdata = 64'hDEADBEEF;
        #1;
        checkOutput("fetch_gnt", {62'd0, imem_gnt, dmem_gnt}, 64'd2);
        checkOutput("fetch_rdata", imem_rdata, 64'hDEADBEEF);
        @(negedge g_clk);
        imem_req = 1'b0; mem_gnt = 1'b0;
        #1;
        checkOutput("store_addr", mem_addr, 64'h2000);
        checkOutput("store_ctl", {55'd0, mem_wen, mem_strb}, {55'd0, 1'b1, 8'h0F});
        @(negedge g_clk);
        dmem_wen = 1'b0; mem_gnt = 1'b1; mem_err = 1'b1;
        #1;
        checkOutput("load_err", {62'd0, imem_err, dmem_err}, 64'd1);
        @(negedge g_clk);
        dmem_req = 1'b0; mem_gnt = 1'b0; mem_err = 1'b0;

        // Continuous conflict with zero-wait memory: fairness pattern.
        doReset();
        hPat = '0;
        hCnt = 0;
        applyStimulus(6, 0, 100);
        checkOutput("conflict_count", 64'(hCnt), 64'd6);
`ifdef CORE_MEM_ARB_RR_EN
        checkOutput("conflict_pattern", {58'd0, hPat}, {58'd0, 6'b101010});
`else
        checkOutput("conflict_pattern", {58'd0, hPat}, {58'd0, 6'b000010});
`endif
        applyStimulus(300, 2, 70);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
